// File: rtl/clk_gate_req_ctrl.sv
// Requester-side clock-gating controller: wake latency, idle hysteresis and min-off window.
// Optional activity statistics are enabled with the CLK_GATE_STATS_EN macro.
module clk_gate_req_ctrl #(
  parameter int NUM_SRC        = 4,
  parameter int WAKE_CYCLES    = 3,
  parameter int IDLE_CYCLES    = 8,
  parameter int MIN_OFF_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] work_req,
  input  logic [NUM_SRC-1:0] busy,
  input  logic               force_on,
`ifdef CLK_GATE_STATS_EN
  input  logic               stats_clr,
  output logic [15:0]        wake_cnt,
  output logic [31:0]        off_cycles,
`endif
  output logic               active,
  output logic               clk_ready,
  output logic [1:0]         state_o
);

  localparam int MAX_WI  = (WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES;
  localparam int CNT_MAX = (MAX_WI > MIN_OFF_CYCLES) ? MAX_WI : MIN_OFF_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYCLES - 1);
  localparam logic [CW-1:0] IDLE_LOAD = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LOAD  = CW'(MIN_OFF_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next, cnt_dec;
  logic          active_reg, active_next;
  logic          ready_reg, ready_next;
  logic [NUM_SRC-1:0] src_act;
  logic          act, wake;

  // Per-source activity: a source is active while requesting or still busy.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign src_act[gi] = work_req[gi] | busy[gi];
  end

  assign act     = (|src_act) | force_on;
  assign wake    = (|work_req) | force_on;
  assign cnt_dec = (cnt_reg == '0) ? '0 : cnt_reg - CW'(1);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_OFF: begin
        if (wake && cnt_reg == '0) begin
          state_next = ST_WAKE;
          cnt_next   = WAKE_LOAD;
        end else begin
          cnt_next = cnt_dec;
        end
      end
      ST_WAKE: begin
        if (cnt_reg == '0) state_next = ST_ON;
        else               cnt_next   = cnt_dec;
      end
      ST_ON: begin
        if (!act) begin
          state_next = ST_DRAIN;
          cnt_next   = IDLE_LOAD;
        end
      end
      ST_DRAIN: begin
        // Activity in the final drain cycle still wins over shutting down.
        if (act) begin
          state_next = ST_ON;
        end else if (cnt_reg == '0) begin
          state_next = ST_OFF;
          cnt_next   = OFF_LOAD;
        end else begin
          cnt_next = cnt_dec;
        end
      end
      default: begin
        state_next = ST_OFF;
        cnt_next   = OFF_LOAD;
      end
    endcase
  end

  // Outputs are registered copies decoded from the next state.
  always_comb begin
    active_next = (state_next != ST_OFF);
    ready_next  = (state_next == ST_ON) || (state_next == ST_DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_OFF;
      cnt_reg    <= OFF_LOAD;
      active_reg <= 1'b0;
      ready_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      active_reg <= active_next;
      ready_reg  <= ready_next;
    end
  end

  assign active    = active_reg;
  assign clk_ready = ready_reg;
  assign state_o   = state_reg;

`ifdef CLK_GATE_STATS_EN
  logic [15:0] wake_cnt_reg;
  logic [31:0] off_cycles_reg;
  logic        wake_evt;

  assign wake_evt = (state_reg == ST_OFF) && (state_next == ST_WAKE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wake_cnt_reg   <= '0;
      off_cycles_reg <= '0;
    end else if (stats_clr) begin
      wake_cnt_reg   <= '0;
      off_cycles_reg <= '0;
    end else begin
      if (wake_evt && wake_cnt_reg != '1)
        wake_cnt_reg <= wake_cnt_reg + 16'd1;
      if (state_reg == ST_OFF && off_cycles_reg != '1)
        off_cycles_reg <= off_cycles_reg + 32'd1;
    end
  end

  assign wake_cnt   = wake_cnt_reg;
  assign off_cycles = off_cycles_reg;
`endif

endmodule
